conv_window_buffer: RTL and testbench
=====================================

// Module: conv_window_buffer
// PURPOSE
//  Streaming line buffer directly upstream of the 5x5 window convolver.
//  - Accepts one 16-bit feature-map pixel per handshake, raster order (row-major, square map).
//  - Emits every stride-1 "valid" KxK window (K = 3 or 5) as a 25-entry array for the
//    multiply/summation stage. One window per handshake, backpressure-aware.
// PARAMETERS
//  DATA_W    16  pixel / window element width (signed)
//  IMG_MAX   32  maximum map width = height; sizes line RAMs and counters
//  K_MAX     5   maximum kernel size; window array holds K_MAX*K_MAX entries
// PORTS
//  clk          in   1          rising-edge clock
//  rst_n        in   1          async active-low reset
//  start        in   1          1-cycle pulse; begins one map; ignored unless IDLE
//  img_dim      in   6          map width=height, sampled on start, 5..IMG_MAX (K..IMG_MAX)
//  filter_size  in   3          kernel K, sampled on start; 3 or 5 only
//  pix_valid    in   1          upstream pixel valid
//  pix_data     in   DATA_W     signed pixel
//  pix_ready    out  1          buffer can accept pixel this cycle
//  win_valid    out  1          window[] holds a valid window
//  win_ready    in   1          downstream accepts window
//  window       out  DATA_W x25 signed [15:0] window [0:24]
//  busy         out  1          high from start until done
//  done         out  1          1-cycle pulse after last window accepted
// BEHAVIOUR
//  - Reset (any time, incl. mid-map): state=IDLE, counters=0, pix_ready=0, win_valid=0,
//    window all 0, busy=0, done=0; line-RAM contents don't-care (never read before rewritten).
//  - FSM: IDLE -start-> RUN; RUN -last pixel accepted-> DRAIN; DRAIN -last window
//    accepted-> DONE; DONE -> IDLE next cycle (done=1 in DONE only). busy=1 in RUN/DRAIN/DONE.
//  - Pixel accepted when pix_valid && pix_ready. pix_ready = (state==RUN) && (!win_valid || win_ready).
//  - Counters row,col (0..img_dim-1) advance on accepted pixel; col wraps to 0 and row
//    increments at col==img_dim-1.
//  - K-1 row-delay lines plus KxK shift register; column entering = {line[K-2]..line[0], pix}.
//  - Window produced by the pixel at (row,col) iff row>=K-1 && col>=K-1; win_valid rises
//    the cycle after that pixel is accepted (latency 1); holds, window stable, until win_ready.
//  - Simultaneous win_valid&&win_ready and new accept: register reloads same edge, no bubble.
//  - Window packing: element (r,c), r=0 top row, c=0 left col, at index r*K+c; indices
//    >= K*K driven 0 (K=3 -> window[9..24]=0).
//  - Windows per map = (img_dim-K+1)^2. Pixels in IDLE/DRAIN/DONE not accepted.
//  - filter_size not 3 or 5 at start: treated as 5. img_dim < K at start: start ignored.
//  - No arithmetic: pure data movement; values pass bit-exact.
// CONFIGURATION
//  STRIDE2_EN defined: extra input stride2 (1 bit, sampled on start); when 1 a window is
//    emitted only if (row-K+1) and (col-K+1) are both even -> floor((img_dim-K)/2+1)^2
//    windows; buffering/pixel acceptance unchanged.
//  STRIDE2_EN undefined: no stride2 port; stride fixed at 1.
// STRUCTURE
//  - cnn_pkg: DATA_W, K_MAX, IMG_MAX constants; typedef logic signed [DATA_W-1:0] pixel_t;
//    typedef pixel_t window_t [0:K_MAX*K_MAX-1]; enum {IDLE,RUN,DRAIN,DONE} wbuf_state_t.
//  - Sub-module line_delay: one row-delay line (IMG_MAX-deep circular RAM, depth = img_dim,
//    read-before-write on shift enable); instantiated K_MAX-1 times.
// TESTING
//  1 K=5, img_dim=5, pixels 0..24 -> exactly 1 window, window[i]=i, done 1 cycle after accept.
//  2 K=3, img_dim=5, pixels 0..24 -> 9 windows; first {0,1,2,5,6,7,10,11,12}, rest 0;
//    last window[0]=12, window[8]=24.
//  3 K=5, img_dim=28, win_ready held 0 for 10 cycles mid-map -> pix_ready=0, window stable,
//    576 windows total, none lost/duplicated vs. golden model.
//  4 Negative data (-32768, -1, 32767 patterns) -> bit-exact passthrough.
//  5 rst_n low mid-map -> all outputs 0 async; new start after reset yields correct windows.
//  6 STRIDE2_EN, K=5, img_dim=28, stride2=1 -> 144 windows at even offsets; stride2=0 -> 576.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and types for the convolution window buffer.
package cnn_pkg;

    localparam int DATA_W  = 16;
    localparam int IMG_MAX = 32;
    localparam int K_MAX   = 5;
    localparam int WIN_N   = K_MAX * K_MAX;
    localparam int DIM_W   = 6;
    localparam int PTR_W   = $clog2(IMG_MAX);

    typedef logic signed [DATA_W-1:0] pixel_t;
    typedef pixel_t window_t [0:WIN_N-1];

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} wbuf_state_t;

    // Only 3 is honoured as a small kernel; anything else runs as 5x5.
    function automatic logic [2:0] eff_k(input logic [2:0] fs);
        return (fs == 3'd3) ? 3'd3 : 3'd5;
    endfunction

endpackage

// File: rtl/line_delay.sv
// One row-delay line: circular RAM whose output is the pixel shifted in dim_i shifts ago.
module line_delay
    import cnn_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [DIM_W-1:0] dim_i,
    input  pixel_t           din_i,
    output pixel_t           dout_o
);

    pixel_t            mem_q [0:IMG_MAX-1];
    logic [PTR_W-1:0]  ptr_q;
    logic [PTR_W-1:0]  ptr_d;

    // Read-before-write: the slot about to be overwritten is the oldest entry.
    assign dout_o = mem_q[ptr_q];

    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            if ({1'b0, ptr_q} == dim_i - 6'd1) ptr_d = '0;
            else                               ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (en_i) mem_q[ptr_q] <= din_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     ptr_q <= '0;
        else if (clr_i) ptr_q <= '0;
        else            ptr_q <= ptr_d;
    end

endmodule

// File: rtl/conv_window_buffer.sv
// Raster-order line buffer emitting every KxK (K=3/5) window of a square feature map.
// Build option STRIDE2_EN adds a stride2 input that keeps only even-offset windows.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting pixels, emitting windows
// DRAIN | all pixels in, waiting for last window to be taken
// DONE  | one-cycle done pulse
module conv_window_buffer
    import cnn_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [DIM_W-1:0]         img_dim,
    input  logic [2:0]               filter_size,
`ifdef STRIDE2_EN
    input  logic                     stride2,
`endif
    input  logic                     pix_valid,
    input  logic signed [DATA_W-1:0] pix_data,
    output logic                     pix_ready,
    output logic                     win_valid,
    input  logic                     win_ready,
    output pixel_t                   window [0:WIN_N-1],
    output logic                     busy,
    output logic                     done
);

    wbuf_state_t       state_q;
    logic              busy_q;
    logic              done_q;
    logic              win_valid_q;
    logic [DIM_W-1:0]  dim_q;
    logic [DIM_W-1:0]  row_q;
    logic [DIM_W-1:0]  col_q;
    logic              k5_q;
`ifdef STRIDE2_EN
    logic              s2_q;
`endif

    pixel_t sr_q     [0:K_MAX-1][0:K_MAX-1];
    pixel_t col_in   [0:K_MAX-1];
    pixel_t line_out [0:K_MAX-2];

    logic [2:0]       k_start;
    logic             start_ok;
    logic             accept;
    logic             last_pix;
    logic             stride_ok;
    logic             produce;
    logic [DIM_W-1:0] kmin1;

    assign k_start   = eff_k(filter_size);
    // Dimensions above IMG_MAX would overrun the line RAMs, so those starts are dropped too.
    assign start_ok  = start && (state_q == IDLE) && ({3'd0, k_start} <= img_dim)
                       && (img_dim <= DIM_W'(IMG_MAX));
    assign pix_ready = (state_q == RUN) && (!win_valid_q || win_ready);
    assign accept    = pix_valid && pix_ready;
    assign last_pix  = (row_q == dim_q - 6'd1) && (col_q == dim_q - 6'd1);
    assign kmin1     = k5_q ? 6'd4 : 6'd2;

`ifdef STRIDE2_EN
    // K-1 is even for both kernels, so an even offset means an even row/col.
    assign stride_ok = !s2_q || (!row_q[0] && !col_q[0]);
`else
    assign stride_ok = 1'b1;
`endif
    assign produce   = (row_q >= kmin1) && (col_q >= kmin1) && stride_ok;

    assign win_valid = win_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

    for (genvar i = 0; i < K_MAX - 1; i++) begin : g_line
        pixel_t din;
        if (i == 0) begin : g_first
            assign din = pix_data;
        end else begin : g_chain
            assign din = line_out[i-1];
        end
        line_delay u_line (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr_i  (start_ok),
            .en_i   (accept),
            .dim_i  (dim_q),
            .din_i  (din),
            .dout_o (line_out[i])
        );
    end

    // Bottom row is the live pixel, oldest line on top; a 3x3 uses the lower-right corner.
    always_comb begin
        col_in[K_MAX-1] = pix_data;
        for (int j = 0; j < K_MAX - 1; j++) col_in[j] = line_out[K_MAX-2-j];
    end

    always_comb begin
        for (int i = 0; i < WIN_N; i++) window[i] = '0;
        if (k5_q) begin
            for (int r = 0; r < K_MAX; r++)
                for (int c = 0; c < K_MAX; c++)
                    window[r*K_MAX+c] = sr_q[r][c];
        end else begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    window[r*3+c] = sr_q[r+K_MAX-3][c+K_MAX-3];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept && last_pix) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (!win_valid_q || win_ready) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q       <= '0;
            col_q       <= '0;
            dim_q       <= '0;
            k5_q        <= 1'b0;
            win_valid_q <= 1'b0;
`ifdef STRIDE2_EN
            s2_q        <= 1'b0;
`endif
            for (int r = 0; r < K_MAX; r++)
                for (int c = 0; c < K_MAX; c++)
                    sr_q[r][c] <= '0;
        end else if (start_ok) begin
            row_q       <= '0;
            col_q       <= '0;
            dim_q       <= img_dim;
            k5_q        <= (k_start == 3'd5);
            win_valid_q <= 1'b0;
`ifdef STRIDE2_EN
            s2_q        <= stride2;
`endif
        end else if (accept) begin
            if (col_q == dim_q - 6'd1) begin
                col_q <= '0;
                row_q <= row_q + 6'd1;
            end else begin
                col_q <= col_q + 6'd1;
            end
            win_valid_q <= produce;
            for (int r = 0; r < K_MAX; r++) begin
                for (int c = 0; c < K_MAX - 1; c++) sr_q[r][c] <= sr_q[r][c+1];
                sr_q[r][K_MAX-1] <= col_in[r];
            end
        end else if (win_ready) begin
            win_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed bench for conv_window_buffer: golden windows computed straight from the map.
`timescale 1ns/1ps
module tb_conv_window_buffer;
    import cnn_pkg::*;

    localparam int WB = 400;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [5:0]   img_dim;
    logic [2:0]   filter_size;
`ifdef STRIDE2_EN
    logic         stride2;
`endif
    logic         pix_valid;
    logic signed [15:0] pix_data;
    logic         pix_ready;
    logic         win_valid;
    logic         win_ready;
    pixel_t       window_s [0:24];
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_errs   = 0;

    logic [15:0]   img [0:1023];
    logic [WB-1:0] exp_q [$];
    logic [WB-1:0] last_win;
    logic [15:0]   neg_vals [0:5];

    conv_window_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .img_dim     (img_dim),
        .filter_size (filter_size),
`ifdef STRIDE2_EN
        .stride2     (stride2),
`endif
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_ready   (pix_ready),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .window      (window_s),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WB-1:0] pack_win();
        logic [WB-1:0] v;
        v = '0;
        for (int i = 0; i < 25; i++) v[i*16 +: 16] = window_s[i];
        return v;
    endfunction

    // pat: 0 ramp, 1 extreme signed values, 2 random
    task automatic run_map(input int dim, input int fs, input bit s2, input int pat,
                           input int gap, input int stall_at, input string tag);
        int k, n, step, pix_idx, win_cnt, cyc, last_acc;
        bit acc_pix, acc_win, seen_done;
        logic [WB-1:0] got, w;
        k    = (fs == 3) ? 3 : 5;
        n    = dim * dim;
        step = s2 ? 2 : 1;
        for (int i = 0; i < n; i++) begin
            case (pat)
                0:       img[i] = 16'(i);
                1:       img[i] = neg_vals[i % 6];
                default: img[i] = 16'($urandom);
            endcase
        end
        exp_q.delete();
        for (int r0 = 0; r0 <= dim - k; r0 += step)
            for (int c0 = 0; c0 <= dim - k; c0 += step) begin
                w = '0;
                for (int r = 0; r < k; r++)
                    for (int c = 0; c < k; c++)
                        w[(r*k+c)*16 +: 16] = img[(r0+r)*dim + c0 + c];
                exp_q.push_back(w);
            end

        @(posedge clk); #1;
        img_dim     = 6'(dim);
        filter_size = 3'(fs);
`ifdef STRIDE2_EN
        stride2     = s2;
`endif
        start       = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        pix_idx   = 0;
        win_cnt   = 0;
        cyc       = 0;
        last_acc  = -10;
        seen_done = 1'b0;
        pix_valid = (gap == 0);
        pix_data  = img[0];
        win_ready = !(stall_at == 0);

        while (!seen_done && cyc < 5000) begin
            @(negedge clk);
            if (done) begin
                seen_done = 1'b1;
                chk({tag, "/done_lat"}, cyc - last_acc, 1);
                chk({tag, "/busy_at_done"}, busy, 1'b1);
            end else begin
                acc_pix = pix_valid && pix_ready;
                acc_win = win_valid && win_ready;
                got     = pack_win();
                if (acc_win) begin
                    if (win_cnt < exp_q.size()) chk({tag, "/win"}, got, exp_q[win_cnt]);
                    else chk({tag, "/extra_win"}, win_cnt, exp_q.size());
                    last_win = got;
                    win_cnt++;
                    last_acc = cyc;
                end else if (win_valid && !win_ready) begin
                    chk({tag, "/stall_pix_ready"}, pix_ready, 1'b0);
                    if (win_cnt < exp_q.size()) chk({tag, "/stall_win"}, got, exp_q[win_cnt]);
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (acc_pix) pix_idx++;
            pix_valid = (pix_idx < n) && !(gap != 0 && (cyc % gap) == 0);
            pix_data  = (pix_idx < n) ? img[pix_idx] : 16'h0;
            win_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 10);
        end
        chk({tag, "/done_seen"}, seen_done, 1'b1);
        chk({tag, "/win_count"}, win_cnt, exp_q.size());
        chk({tag, "/pix_count"}, pix_idx, n);
        @(negedge clk);
        chk({tag, "/done_pulse_end"}, done, 1'b0);
        chk({tag, "/busy_end"}, busy, 1'b0);
        pix_valid = 1'b0;
        win_ready = 1'b0;
    endtask

    initial begin
        neg_vals[0] = 16'h8000;
        neg_vals[1] = 16'hFFFF;
        neg_vals[2] = 16'h7FFF;
        neg_vals[3] = 16'h0001;
        neg_vals[4] = 16'hFFFE;
        neg_vals[5] = 16'h8001;
        last_win    = '0;
        rst_n       = 1'b0;
        start       = 1'b0;
        img_dim     = '0;
        filter_size = '0;
`ifdef STRIDE2_EN
        stride2     = 1'b0;
`endif
        pix_valid   = 1'b0;
        pix_data    = '0;
        win_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/pix_ready", pix_ready, 1'b0);
        chk("rst/win_valid", win_valid, 1'b0);
        chk("rst/busy", busy, 1'b0);
        chk("rst/done", done, 1'b0);
        chk("rst/window", pack_win(), '0);
        rst_n = 1'b1;

        run_map(5, 5, 1'b0, 0, 0, -1, "k5d5");
        chk("k5d5/w12", last_win[12*16 +: 16], 12);
        chk("k5d5/w24", last_win[24*16 +: 16], 24);

        run_map(5, 3, 1'b0, 0, 0, -1, "k3d5");
        chk("k3d5/last_w0", last_win[0 +: 16], 12);
        chk("k3d5/last_w8", last_win[8*16 +: 16], 24);
        chk("k3d5/upper_zero", last_win[WB-1:144], '0);

        run_map(28, 5, 1'b0, 2, 0, 300, "k5d28_stall");
        run_map(6, 3, 1'b0, 1, 3, -1, "neg_k3");
        run_map(5, 5, 1'b0, 1, 0, -1, "neg_k5");
        chk("neg_k5/w0", last_win[0 +: 16], 16'h8000);
        chk("neg_k5/w2", last_win[2*16 +: 16], 16'h7FFF);

        // starts with img_dim below K must be dropped
        @(posedge clk); #1;
        img_dim = 6'd4; filter_size = 3'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("ign_d4k5/busy", busy, 1'b0);
        @(posedge clk); #1;
        img_dim = 6'd2; filter_size = 3'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("ign_d2k3/busy", busy, 1'b0);

        run_map(5, 7, 1'b0, 0, 0, -1, "fs7_as5");

        // asynchronous reset in the middle of a map
        @(posedge clk); #1;
        img_dim = 6'd8; filter_size = 3'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; pix_valid = 1'b1; win_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            pix_data = 16'(i * 7 + 1);
            @(posedge clk); #1;
        end
        chk("mid/busy_before", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst/pix_ready", pix_ready, 1'b0);
        chk("mid_rst/win_valid", win_valid, 1'b0);
        chk("mid_rst/busy", busy, 1'b0);
        chk("mid_rst/done", done, 1'b0);
        chk("mid_rst/window", pack_win(), '0);
        pix_valid = 1'b0; win_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_map(6, 3, 1'b0, 2, 0, -1, "after_rst");

`ifdef STRIDE2_EN
        run_map(28, 5, 1'b1, 2, 0, -1, "s2_on");
        run_map(28, 5, 1'b0, 0, 0, -1, "s2_off");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
